mem_stage: RTL

//   Memory-access stage of the 5-stage ARM pipeline. Sits downstream of the execute stage, behind the EXE/MEM register.

---
 rtl/mem_stage.sv | 99 +++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: multi-cycle LDR/STR against an internal word-addressed
// data memory, with freeze held high upstream until the access completes.
module mem_stage #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] val_rm_in,
  input  logic [3:0]  dest_in,
  output logic        wb_en,
  output logic        mem_r_en,
  output logic [31:0] alu_result,
  output logic [3:0]  dest,
  output logic [31:0] mem_data,
  output logic        freeze
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [31:0]     r_mem_data;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_req;
  logic            w_done_edge;
  logic [31:0]     w_offset;
  logic [AW-1:0]   w_index;
  logic            w_unused_offset;

  assign wb_en      = wb_en_in;
  assign mem_r_en   = mem_r_en_in;
  assign alu_result = alu_result_in;
  assign dest       = dest_in;
  assign mem_data   = r_mem_data;

  assign w_req  = mem_r_en_in | mem_w_en_in;
  assign freeze = w_req & (r_state != S_DONE);

  // Modulo-2^32 offset; dropping high bits gives the wrap modulo DEPTH_WORDS.
  assign w_offset        = alu_result_in - 32'(ADDR_BASE);
  assign w_index         = w_offset[AW+1:2];
  assign w_unused_offset = ^{w_offset[31:AW+2], w_offset[1:0]};

  assign w_done_edge = (r_state == S_WAIT) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT: begin
        if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
        else                   w_cnt_nxt   = r_cnt + CW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mem_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      // Read sees the pre-write word, so a read+write pair returns old data.
      if (w_done_edge && mem_r_en_in) r_mem_data <= r_mem[w_index];
    end
  end

  always_ff @(posedge clk) begin
    if (w_done_edge && mem_w_en_in) r_mem[w_index] <= val_rm_in;
  end

endmodule
